th_gate_bank: RTL and testbench



---
 rtl/th_pkg.sv | 30 +++
 rtl/th_gate_ch.sv | 77 +++++++
 rtl/th_gate_bank.sv | 82 ++++++++
 tb/tb_th_gate_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/th_pkg.sv
// Shared types and helpers for the NCL threshold gate bank.
package th_pkg;

  typedef enum logic {ENC_FP, ENC_TP} enc_e;
  typedef enum logic {StNull, StData} fp_state_e;

  localparam int unsigned MaxIn = 8;

  function automatic enc_e th_enc_from_str(input string s);
    return (s == "TP") ? ENC_TP : ENC_FP;
  endfunction

  function automatic int unsigned th_sum_width(input int unsigned in_num,
                                               input int unsigned weight0);
    return $clog2(in_num + weight0) + 1;
  endfunction

  // Input 0 carries weight0; the rest weigh 1. Bits at or above in_num are ignored.
  function automatic int unsigned th_weighted_count(input logic [MaxIn-1:0] x,
                                                    input int unsigned in_num,
                                                    input int unsigned weight0);
    int unsigned cnt;
    cnt = x[0] ? weight0 : 0;
    for (int unsigned i = 1; i < MaxIn; i++) begin
      if (i < in_num && x[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/th_gate_ch.sv
// One registered threshold gate channel: FP hysteresis FSM or TP transition capture.
module th_gate_ch import th_pkg::*; #(
  parameter int unsigned IN_NUM  = 4,
  parameter int unsigned THRESH  = 2,
  parameter int unsigned WEIGHT0 = 1,
  parameter enc_e        MODE    = ENC_FP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_NUM-1:0] in,
  output logic              out
);

  localparam int unsigned   SW      = th_sum_width(IN_NUM, WEIGHT0);
  localparam logic [SW-1:0] ThreshW = SW'(THRESH);

  logic [SW-1:0] sum;

  if (MODE == ENC_TP) begin : g_tp
    logic [IN_NUM-1:0] last_q, last_d, p_q, p_d, p_next;
    logic              out_q, out_d;

    always_comb begin
      // A second edge on an input before firing cancels the first.
      p_next = p_q ^ (in ^ last_q);
      sum    = SW'(th_weighted_count(MaxIn'(p_next), IN_NUM, WEIGHT0));
      out_d  = out_q;
      p_d    = p_q;
      last_d = last_q;
      if (en) begin
        last_d = in;
        p_d    = p_next;
        if (sum >= ThreshW) begin
          out_d = ~out_q;
          p_d   = '0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q  <= 1'b0;
        p_q    <= '0;
        last_q <= '0;
      end else begin
        out_q  <= out_d;
        p_q    <= p_d;
        last_q <= last_d;
      end
    end

    assign out = out_q;
  end else begin : g_fp
    fp_state_e state_q, state_d;

    always_comb begin
      sum     = SW'(th_weighted_count(MaxIn'(in), IN_NUM, WEIGHT0));
      state_d = state_q;
      if (en) begin
        unique case (state_q)
          StNull:  if (sum >= ThreshW) state_d = StData;
          StData:  if (in == '0)       state_d = StNull;
          default: state_d = StNull;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) state_q <= StNull;
      else     state_q <= state_d;
    end

    assign out = (state_q == StData);
  end

endmodule

// File: rtl/th_gate_bank.sv
// Bank of CH independent registered NCL threshold gates.
// Optional bank completion flag `done` is built when TH_BANK_DONE_EN is defined.
module th_gate_bank import th_pkg::*; #(
  parameter int unsigned CH      = 4,
  parameter int unsigned IN_NUM  = 4,
  parameter int unsigned THRESH  = 2,
  parameter int unsigned WEIGHT0 = 1,
  parameter string       ENC     = "FP"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH-1:0]        en,
  input  logic [CH*IN_NUM-1:0] in,
  output logic [CH-1:0]        out
`ifdef TH_BANK_DONE_EN
  ,
  output logic                 done
`endif
);

  localparam enc_e Mode = th_enc_from_str(ENC);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    th_gate_ch #(
      .IN_NUM (IN_NUM),
      .THRESH (THRESH),
      .WEIGHT0(WEIGHT0),
      .MODE   (Mode)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .en (en[c]),
      .in (in[c*IN_NUM +: IN_NUM]),
      .out(out[c])
    );
  end

`ifdef TH_BANK_DONE_EN
  logic done_q, done_d;
  logic all_eq;

  assign all_eq = (&out) | ~(|out);

  if (Mode == ENC_TP) begin : g_done_tp
    logic [CH-1:0] prev_q;
    logic          pend_q, pend_d, pend;

    always_comb begin
      // Pending until every channel has caught up to the same phase.
      pend   = pend_q | (out != prev_q);
      done_d = pend & all_eq;
      pend_d = pend & ~all_eq;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q <= '0;
        pend_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        prev_q <= out;
        pend_q <= pend_d;
        done_q <= done_d;
      end
    end
  end else begin : g_done_fp
    always_comb begin
      done_d = done_q;
      if (&out)        done_d = 1'b1;
      else if (~|out)  done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_th_gate_bank.sv
// Directed bench for th_gate_bank: FP, weighted FP and TP instances with a scoreboard queue.
module tb_th_gate_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_fp, en_w, en_tp;
  logic [15:0] in_fp, in_w, in_tp;
  logic [3:0]  out_fp, out_w, out_tp;
`ifdef TH_BANK_DONE_EN
  logic        done_fp, done_w, done_tp;
`endif

  always #5 clk = ~clk;

  th_gate_bank #(.CH(4), .IN_NUM(4), .THRESH(3), .WEIGHT0(1), .ENC("FP")) dut_fp (
    .clk(clk), .rst(rst), .en(en_fp), .in(in_fp), .out(out_fp)
`ifdef TH_BANK_DONE_EN
    , .done(done_fp)
`endif
  );

  th_gate_bank #(.CH(4), .IN_NUM(4), .THRESH(3), .WEIGHT0(2), .ENC("FP")) dut_w (
    .clk(clk), .rst(rst), .en(en_w), .in(in_w), .out(out_w)
`ifdef TH_BANK_DONE_EN
    , .done(done_w)
`endif
  );

  th_gate_bank #(.CH(4), .IN_NUM(4), .THRESH(2), .WEIGHT0(1), .ENC("TP")) dut_tp (
    .clk(clk), .rst(rst), .en(en_tp), .in(in_tp), .out(out_tp)
`ifdef TH_BANK_DONE_EN
    , .done(done_tp)
`endif
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [3:0]  exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  function automatic logic [3:0] observe(input int unsigned sel);
    case (sel)
      0: return out_fp;
      1: return out_w;
      2: return out_tp;
`ifdef TH_BANK_DONE_EN
      3: return {3'b000, done_fp};
      4: return {3'b000, done_w};
      5: return {3'b000, done_tp};
`endif
      default: return 4'bxxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int unsigned sel, input logic [3:0] exp);
    sb.push_back('{tag, sel, exp});
  endtask

  // Advance one clock, then retire every pending expectation.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (observe(e.sel) === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%b expected=%b", e.tag, observe(e.sel), e.exp);
      end
    end
  endtask

  initial begin
    int fire [4] = '{3, 5, 6, 9};
    logic [3:0] exp_bits;

    rst   = 1'b1;
    en_fp = 4'hF; en_w = 4'hF; en_tp = 4'hF;
    in_fp = 16'hFFFF; in_w = 16'h0000; in_tp = 16'h0000;

    // Reset overrides qualifying inputs.
    expect_val("rst_fp", 0, 4'b0000);
    expect_val("rst_w", 1, 4'b0000);
    expect_val("rst_tp", 2, 4'b0000);
`ifdef TH_BANK_DONE_EN
    expect_val("rst_done_fp", 3, 4'b0000);
`endif
    tick();
    rst = 1'b0;
    expect_val("rel_fp", 0, 4'b1111);
    expect_val("rel_tp", 2, 4'b0000);
    tick();

    // FP hysteresis, THRESH=3.
    in_fp = 16'h0000; expect_val("fp_null", 0, 4'b0000); tick();
    in_fp = 16'h3333; expect_val("fp_below", 0, 4'b0000); tick();
    in_fp = 16'h7777; expect_val("fp_fire", 0, 4'b1111); tick();
    in_fp = 16'h1111; expect_val("fp_partial_hold", 0, 4'b1111); tick();
    in_fp = 16'h0000; expect_val("fp_release", 0, 4'b0000); tick();
    in_fp = 16'h8B37; expect_val("fp_mixed", 0, 4'b0101); tick();
    in_fp = 16'h0000; expect_val("fp_mixed_rel", 0, 4'b0000); tick();

    // Weighted input 0, WEIGHT0=2, THRESH=3.
    in_w = 16'h6666; expect_val("w_0110", 1, 4'b0000); tick();
    in_w = 16'h3333; expect_val("w_0011", 1, 4'b1111); tick();
    in_w = 16'h0000; expect_val("w_null", 1, 4'b0000);
`ifdef TH_BANK_DONE_EN
    expect_val("w_done_set", 4, 4'b0001);
`endif
    tick();
    in_w = 16'h9999; expect_val("w_1001", 1, 4'b1111);
`ifdef TH_BANK_DONE_EN
    expect_val("w_done_clr", 4, 4'b0000);
`endif
    tick();

    // TP transition capture, THRESH=2.
    in_tp = 16'h1111; expect_val("tp_one_edge", 2, 4'b0000); tick();
    in_tp = 16'h5555; expect_val("tp_fire_up", 2, 4'b1111); tick();
    in_tp = 16'h7777; expect_val("tp_toggle1a", 2, 4'b1111);
`ifdef TH_BANK_DONE_EN
    expect_val("tp_done_pulse", 5, 4'b0001);
`endif
    tick();
    in_tp = 16'h5555; expect_val("tp_toggle1b", 2, 4'b1111);
`ifdef TH_BANK_DONE_EN
    expect_val("tp_done_end", 5, 4'b0000);
`endif
    tick();
    in_tp = 16'hDDDD; expect_val("tp_edge3", 2, 4'b1111); tick();
    in_tp = 16'hCCCC; expect_val("tp_fire_down", 2, 4'b0000); tick();
    in_tp = 16'hFFFF; expect_val("tp_two_edges", 2, 4'b1111); tick();
    expect_val("tp_idle", 2, 4'b1111); tick();
    in_tp = 16'h8888; expect_val("tp_three_edges", 2, 4'b0000); tick();
    in_tp = 16'h0000; expect_val("tp_not_recaptured", 2, 4'b0000); tick();
    in_tp = 16'h1111; expect_val("tp_refire", 2, 4'b1111); tick();
    en_tp = 4'h0; in_tp = 16'h7777; expect_val("tp_frozen_a", 2, 4'b1111); tick();
    in_tp = 16'h3333; expect_val("tp_frozen_b", 2, 4'b1111); tick();
    en_tp = 4'hF; expect_val("tp_reenable", 2, 4'b1111); tick();
    in_tp = 16'hBBBB; expect_val("tp_after_en", 2, 4'b0000); tick();
    in_tp = 16'hBBBE; expect_val("tp_ch0_only", 2, 4'b0001); tick();

    // Enable freeze on the FP instance.
    en_fp = 4'h0; in_fp = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      expect_val("en_freeze", 0, 4'b0000); tick();
    end
    en_fp = 4'hF; expect_val("en_resume", 0, 4'b1111); tick();
    en_fp = 4'h0; rst = 1'b1; expect_val("rst_over_en", 0, 4'b0000); tick();
    rst = 1'b0; expect_val("frozen_after_rst", 0, 4'b0000); tick();
    en_fp = 4'b0101; expect_val("en_partial", 0, 4'b0101); tick();
    en_fp = 4'hF; in_fp = 16'h0000; expect_val("en_all_rel", 0, 4'b0000); tick();

`ifdef TH_BANK_DONE_EN
    // Staggered channel completion on the FP instance.
    for (int cyc = 1; cyc <= 10; cyc++) begin
      exp_bits = 4'b0000;
      for (int c = 0; c < 4; c++) begin
        if (cyc >= fire[c]) begin
          in_fp[c*4 +: 4] = 4'h7;
          exp_bits[c] = 1'b1;
        end
      end
      expect_val("done_out", 0, exp_bits);
      expect_val("done_stagger", 3, (cyc >= 10) ? 4'b0001 : 4'b0000);
      tick();
    end
    in_fp = 16'h0000;
    expect_val("done_drop_out", 0, 4'b0000);
    expect_val("done_hold", 3, 4'b0001);
    tick();
    expect_val("done_clear", 3, 4'b0000);
    tick();
`else
    exp_bits = 4'b0000;
    if (fire[0] != 3) exp_bits = 4'b1111;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
